// File: rtl/sha3_pad_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface : sha3_pad_buffer_if
// Desc      : Message-word input and rate-block output bus of sha3_pad_buffer.
// Rev       : 1.0
// ============================================================================
interface sha3_pad_buffer_if #(
  parameter int LANE_W     = 64,
  parameter int RATE_LANES = 17
);
  logic                         i_start;
  logic                         i_in_valid;
  logic                         o_in_ready;
  logic [LANE_W-1:0]            i_in_data;
  logic                         i_in_last;
  logic [3:0]                   i_in_bytes;
  logic                         i_block_ack;
  logic [RATE_LANES*LANE_W-1:0] o_block_out;
  logic                         o_buff_full;
  logic                         o_last;
  logic                         o_first;

  modport master (
    output i_start, i_in_valid, i_in_data, i_in_last, i_in_bytes, i_block_ack,
    input  o_in_ready, o_block_out, o_buff_full, o_last, o_first
  );

  modport slave (
    input  i_start, i_in_valid, i_in_data, i_in_last, i_in_bytes, i_block_ack,
    output o_in_ready, o_block_out, o_buff_full, o_last, o_first
  );
endinterface
`default_nettype wire

// File: rtl/sha3_pad_buffer.sv
`default_nettype none
// ============================================================================
// Module : sha3_pad_buffer
// Desc   : SHA-3 absorb input stage; packs message words into rate blocks and
//          applies DSUFFIX ... 0x80 padding.
// Rev    : 1.0
// ============================================================================
module sha3_pad_buffer #(
  parameter int         LANE_W     = 64,
  parameter int         RATE_LANES = 17,
  parameter logic [7:0] DSUFFIX    = 8'h06
) (
  input  logic               clk,
  input  logic               rst,
  sha3_pad_buffer_if.slave   bus
);
  localparam int IDX_W   = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
  localparam int N_BYTES = LANE_W / 8;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(RATE_LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2,
    S_PAD  = 2'd3
  } state_t;

  state_t                              r_state;
  logic [RATE_LANES-1:0][LANE_W-1:0]   r_lanes;
  logic [IDX_W-1:0]                    r_idx;
  logic                                r_in_ready;
  logic                                r_buff_full;
  logic                                r_last;
  logic                                r_first;
  logic                                r_pad_pend;

  logic                                w_accept;
  logic                                w_full_word;
  logic                                w_overflow;
  logic [LANE_W-1:0]                   w_word;
  logic [RATE_LANES-1:0][LANE_W-1:0]   w_last_lanes;

  assign w_accept = bus.i_in_valid && r_in_ready;

  // Block contents after accepting the final word, padding included.
  always_comb begin
    w_full_word  = (bus.i_in_bytes >= 4'd8);
    w_overflow   = w_full_word && (r_idx == c_last_idx);
    w_word       = '0;
    for (int b = 0; b < N_BYTES; b++) begin
      if (4'(b) < bus.i_in_bytes)
        w_word[8*b +: 8] = bus.i_in_data[8*b +: 8];
      if (!w_full_word && (4'(b) == bus.i_in_bytes))
        w_word[8*b +: 8] = DSUFFIX;
    end
    w_last_lanes        = r_lanes;
    w_last_lanes[r_idx] = w_word;
    if (w_full_word && !w_overflow)
      w_last_lanes[r_idx + 1'b1] = {{(LANE_W-8){1'b0}}, DSUFFIX};
    if (!w_overflow)
      w_last_lanes[RATE_LANES-1][LANE_W-1 -: 8] =
        w_last_lanes[RATE_LANES-1][LANE_W-1 -: 8] | 8'h80;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lanes     <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_buff_full <= 1'b0;
      r_last      <= 1'b0;
      r_first     <= 1'b0;
      r_pad_pend  <= 1'b0;
    end else if (bus.i_start) begin
      r_state     <= S_FILL;
      r_lanes     <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_buff_full <= 1'b0;
      r_last      <= 1'b0;
      r_first     <= 1'b1;
      r_pad_pend  <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            if (bus.i_in_last) begin
              r_lanes     <= w_last_lanes;
              r_last      <= !w_overflow;
              r_pad_pend  <= w_overflow;
              r_state     <= S_FULL;
              r_buff_full <= 1'b1;
              r_in_ready  <= 1'b0;
            end else begin
              r_lanes[r_idx] <= bus.i_in_data;
              if (r_idx == c_last_idx) begin
                r_last      <= 1'b0;
                r_state     <= S_FULL;
                r_buff_full <= 1'b1;
                r_in_ready  <= 1'b0;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end
        end
        S_FULL: begin
          if (bus.i_block_ack) begin
            r_lanes     <= '0;
            r_idx       <= '0;
            r_first     <= 1'b0;
            r_buff_full <= 1'b0;
            r_last      <= 1'b0;
            if (r_last) begin
              r_state <= S_IDLE;
            end else if (r_pad_pend) begin
              r_state <= S_PAD;
            end else begin
              r_state    <= S_FILL;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_PAD: begin
          // Message ended exactly on a block boundary: emit a padding-only block.
          r_lanes[0][7:0]                    <= DSUFFIX;
          r_lanes[RATE_LANES-1][LANE_W-1 -: 8] <= 8'h80;
          r_last      <= 1'b1;
          r_pad_pend  <= 1'b0;
          r_state     <= S_FULL;
          r_buff_full <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_in_ready  = r_in_ready;
  assign bus.o_block_out = r_lanes;
  assign bus.o_buff_full = r_buff_full;
  assign bus.o_last      = r_last;
  assign bus.o_first     = r_first;
endmodule
`default_nettype wire

// File: tb/tb_sha3_pad_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_sha3_pad_buffer
// Desc   : Self-checking bench; byte-level SHA-3 padding model vs. DUT blocks.
// Rev    : 1.0
// ============================================================================
module tb_sha3_pad_buffer;
  localparam int         LANE_W     = 64;
  localparam int         RATE_LANES = 17;
  localparam int         RB         = RATE_LANES * 8;
  localparam logic [7:0] DS         = 8'h06;
  localparam int         BW         = RATE_LANES * LANE_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha3_pad_buffer_if #(.LANE_W(LANE_W), .RATE_LANES(RATE_LANES)) bus ();

  sha3_pad_buffer #(.LANE_W(LANE_W), .RATE_LANES(RATE_LANES), .DSUFFIX(DS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] msg [0:299];
  int         msg_len;
  logic [BW-1:0] exp_blk [0:3];
  int         n_exp;
  int         blk_idx;
  bit         cmp_en = 1'b0;
  int         test_id;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (test %0d): got %h expected %h", name, test_id, act, exp);
    end
  endtask

  task automatic fill_msg(input int tid, input int len);
    msg_len = len;
    for (int j = 0; j < len; j++) msg[j] = 8'(j * 13 + tid * 7 + 1);
  endtask

  // Sponge padding at byte level: msg || DS || 0* || 0x80 up to a rate multiple.
  task automatic build_expected();
    logic [7:0] pb [0:543];
    int p;
    p = ((msg_len + 1 + RB - 1) / RB) * RB;
    for (int j = 0; j < p; j++) pb[j] = (j < msg_len) ? msg[j] : 8'h00;
    pb[msg_len] = pb[msg_len] ^ DS;
    pb[p-1]     = pb[p-1] | 8'h80;
    n_exp = p / RB;
    for (int k = 0; k < n_exp; k++)
      for (int m = 0; m < RB; m++) exp_blk[k][8*m +: 8] = pb[k*RB + m];
  endtask

  task automatic set_word(input int w, input int nwords);
    logic [63:0] d;
    for (int b = 0; b < 8; b++)
      d[8*b +: 8] = (8*w + b < msg_len) ? msg[8*w + b] : 8'hA5;
    bus.i_in_valid = (w < nwords);
    bus.i_in_data  = d;
    bus.i_in_last  = (w == nwords - 1);
    bus.i_in_bytes = (w == nwords - 1) ? 4'(msg_len - 8*(nwords - 1)) : 4'd8;
  endtask

  // Continuous block compare against the model while a block is presented.
  always @(negedge clk) begin
    if (cmp_en && bus.o_buff_full) begin
      checks++;
      if (blk_idx >= n_exp) begin
        errors++;
        $display("FAIL extra_block (test %0d): block %0d beyond expected %0d", test_id, blk_idx, n_exp);
      end else begin
        int bad;
        bad = -1;
        for (int i = 0; i < RATE_LANES; i++)
          if (bad < 0 && bus.o_block_out[64*i +: 64] !== exp_blk[blk_idx][64*i +: 64]) bad = i;
        if (bad >= 0) begin
          errors++;
          $display("FAIL block_lane (test %0d blk %0d lane %0d): got %h expected %h", test_id, blk_idx,
                   bad, bus.o_block_out[64*bad +: 64], exp_blk[blk_idx][64*bad +: 64]);
        end
        chk64("last", 64'(bus.o_last), 64'(blk_idx == n_exp - 1));
        chk64("first", 64'(bus.o_first), 64'(blk_idx == 0));
      end
      chk64("in_ready_in_full", 64'(bus.o_in_ready), 64'd0);
      if (test_id == 0) begin
        chk64("lit_empty_lane0", bus.o_block_out[0 +: 64], 64'h0000_0000_0000_0006);
        chk64("lit_empty_lane16", bus.o_block_out[16*64 +: 64], 64'h8000_0000_0000_0000);
      end
      if (test_id == 1)
        chk64("lit_abc_lane0", bus.o_block_out[0 +: 64], 64'h0000_0000_0663_6261);
      if (test_id == 2)
        chk64("lit_135_byte7", 64'(bus.o_block_out[17*64-1 -: 8]), 64'h86);
      if (test_id == 3 && blk_idx == 1) begin
        chk64("lit_136_pad_lane0", bus.o_block_out[0 +: 64], 64'h0000_0000_0000_0006);
        chk64("lit_136_pad_lane16", bus.o_block_out[16*64 +: 64], 64'h8000_0000_0000_0000);
      end
      if (test_id == 7)
        chk64("lit_128_lane16", bus.o_block_out[16*64 +: 64], 64'h8000_0000_0000_0006);
    end
  end

  task automatic run_msg(input int tid, input int ack_delay);
    int  nwords, w, wait_cnt, cyc;
    bit  acc, ackd, lat_pend, ack_pend, was_last;
    test_id = tid;
    build_expected();
    blk_idx  = 0;
    nwords   = (msg_len == 0) ? 1 : (msg_len + 7) / 8;
    w        = 0;
    wait_cnt = 0;
    cyc      = 0;
    lat_pend = 1'b0;
    ack_pend = 1'b0;
    @(posedge clk); #1 bus.i_start = 1'b1;
    @(posedge clk); #1 bus.i_start = 1'b0;
    cmp_en = 1'b1;
    while (blk_idx < n_exp && cyc < 2000) begin
      set_word(w, nwords);
      bus.i_block_ack = 1'b0;
      if (bus.o_buff_full) begin
        if (wait_cnt >= ack_delay) bus.i_block_ack = 1'b1;
        else wait_cnt++;
      end
      @(negedge clk);
      if (lat_pend) chk64("full_latency", 64'(bus.o_buff_full), 64'd1);
      if (ack_pend) chk64("ack_clears_full", 64'(bus.o_buff_full), 64'd0);
      lat_pend = 1'b0;
      ack_pend = 1'b0;
      acc      = bus.i_in_valid && bus.o_in_ready;
      ackd     = bus.i_block_ack && bus.o_buff_full;
      was_last = bus.i_in_last;
      @(posedge clk); #1;
      if (acc) begin
        if (was_last || ((w + 1) % RATE_LANES == 0)) lat_pend = 1'b1;
        w++;
      end
      if (ackd) begin
        blk_idx++;
        ack_pend = 1'b1;
        wait_cnt = 0;
      end
      cyc++;
    end
    bus.i_in_valid  = 1'b0;
    bus.i_block_ack = 1'b0;
    @(negedge clk);
    chk64("blocks_done", 64'(blk_idx), 64'(n_exp));
    chk64("words_consumed", 64'(w), 64'(nwords));
    chk64("idle_full", 64'(bus.o_buff_full), 64'd0);
    chk64("idle_ready", 64'(bus.o_in_ready), 64'd0);
    cmp_en = 1'b0;
  endtask

  initial begin
    bit got;
    rst             = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_in_valid  = 1'b0;
    bus.i_in_data   = '0;
    bus.i_in_last   = 1'b0;
    bus.i_in_bytes  = '0;
    bus.i_block_ack = 1'b0;
    test_id         = -1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk64("reset_full", 64'(bus.o_buff_full), 64'd0);
    chk64("reset_ready", 64'(bus.o_in_ready), 64'd0);
    chk64("reset_flags", {61'd0, bus.o_last, bus.o_first, 1'b0}, 64'd0);
    chk64("reset_block_or", 64'(|bus.o_block_out), 64'd0);

    fill_msg(0, 0);   run_msg(0, 0);
    msg_len = 3; msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg(1, 0);
    fill_msg(2, 135); run_msg(2, 1);
    fill_msg(3, 136); run_msg(3, 2);
    fill_msg(4, 150); run_msg(4, 3);
    fill_msg(5, 20);  run_msg(5, 1);
    fill_msg(6, 8);   run_msg(6, 0);
    fill_msg(7, 128); run_msg(7, 0);

    // Reset with five words absorbed.
    test_id = 10;
    fill_msg(10, 60);
    @(posedge clk); #1 bus.i_start = 1'b1;
    @(posedge clk); #1 bus.i_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_word(k, 8);
      @(posedge clk); #1;
    end
    bus.i_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk64("midrst_full", 64'(bus.o_buff_full), 64'd0);
    chk64("midrst_ready", 64'(bus.o_in_ready), 64'd0);
    chk64("midrst_flags", {62'd0, bus.o_last, bus.o_first}, 64'd0);
    chk64("midrst_block_or", 64'(|bus.o_block_out), 64'd0);
    fill_msg(12, 60); run_msg(12, 0);

    // start and block_ack in the same cycle: start wins.
    test_id = 11;
    fill_msg(11, 3);
    @(posedge clk); #1 bus.i_start = 1'b1;
    @(posedge clk); #1 bus.i_start = 1'b0;
    set_word(0, 1);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.o_buff_full) got = 1'b1;
    end
    chk64("collide_wait_full", 64'(got), 64'd1);
    @(posedge clk); #1;
    bus.i_in_valid  = 1'b0;
    bus.i_start     = 1'b1;
    bus.i_block_ack = 1'b1;
    @(posedge clk); #1;
    bus.i_start     = 1'b0;
    bus.i_block_ack = 1'b0;
    @(negedge clk);
    chk64("collide_full", 64'(bus.o_buff_full), 64'd0);
    chk64("collide_first", 64'(bus.o_first), 64'd1);
    chk64("collide_ready", 64'(bus.o_in_ready), 64'd1);
    chk64("collide_block_or", 64'(|bus.o_block_out), 64'd0);
    fill_msg(13, 17); run_msg(13, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
